// File: rtl/scroll_pkg.sv
// Shared constants for the scrolling word display: segment patterns, character codes
// and the width helper used by the top level.
package scroll_pkg;

    // Active-low, bit6 = seg g ... bit0 = seg a
    localparam logic [6:0] SEG_D     = 7'b0100001;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam int CH_D    = 0;
    localparam int CH_E    = 1;
    localparam int CH_ONE  = 2;
    localparam int CH_ZERO = 3;

    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/char_to_seg7.sv
// Combinational character-code to active-low 7-segment decoder; unknown codes blank.
module char_to_seg7
    import scroll_pkg::*;
#(
    parameter int CHAR_W = 2
) (
    input  logic [CHAR_W-1:0] code_i,
    output logic [6:0]        seg_o
);

    logic [31:0] code_ext;
    assign code_ext = 32'(code_i);

    always_comb begin
        seg_o = SEG_BLANK;
        case (code_ext)
            32'(CH_D):    seg_o = SEG_D;
            32'(CH_E):    seg_o = SEG_E;
            32'(CH_ONE):  seg_o = SEG_1;
            32'(CH_ZERO): seg_o = SEG_0;
            default:      seg_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/scroll_word_display.sv
// Scrolls a NUM_CHARS word through a NUM_DIGITS window of HEX displays, stepping on a
// prescaler tick or a manual key edge. Define SCROLL_DIR_EN to add the dir port.
module scroll_word_display
    import scroll_pkg::*;
#(
    parameter int NUM_CHARS  = 4,
    parameter int NUM_DIGITS = 4,
    parameter int CHAR_W     = 2,
    parameter int TICK_DIV   = 50000000
) (
    input  logic                          CLOCK_50,
    input  logic                          reset,
    input  logic [NUM_CHARS*CHAR_W-1:0]   char_codes,
    input  logic                          auto_mode,
    input  logic                          pause,
    input  logic                          step,
`ifdef SCROLL_DIR_EN
    input  logic                          dir,
`endif
    output logic [NUM_DIGITS*7-1:0]       hex_segs,
    output logic [clog2_min1(NUM_CHARS)-1:0] offset,
    output logic                          tick
);

    localparam int OW = clog2_min1(NUM_CHARS);
    localparam int PW = clog2_min1(TICK_DIV);
    localparam int IW = OW + 1;

    logic [OW-1:0]              offset_q, offset_d;
    logic [PW-1:0]              presc_q, presc_d;
    logic                       step_q, tick_q;
    logic [NUM_DIGITS*7-1:0]    hex_q;
    logic [NUM_DIGITS-1:0][6:0] seg_w;
    logic                       tick_int, step_rise, adv, dir_w;

`ifdef SCROLL_DIR_EN
    assign dir_w = dir;
`else
    assign dir_w = 1'b0;
`endif

    assign tick_int  = auto_mode & ~pause & (presc_q == PW'(TICK_DIV - 1));
    assign step_rise = step & ~step_q;
    assign adv       = (auto_mode & tick_int) | (~auto_mode & step_rise & ~pause);

    always_comb begin
        presc_d = presc_q;
        if (!auto_mode)
            presc_d = '0;
        else if (!pause)
            presc_d = tick_int ? '0 : presc_q + 1'b1;
    end

    always_comb begin
        offset_d = offset_q;
        if (adv) begin
            if (dir_w)
                offset_d = (offset_q == '0) ? OW'(NUM_CHARS - 1) : offset_q - 1'b1;
            else
                offset_d = (offset_q == OW'(NUM_CHARS - 1)) ? '0 : offset_q + 1'b1;
        end
    end

    // Each digit's distance from offset is constant, so the modulo collapses to one
    // conditional subtract at run time.
    for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_dig
        localparam int R = (NUM_DIGITS - 1 - k) % NUM_CHARS;
        logic [IW-1:0]     sum, idx;
        logic [CHAR_W-1:0] code;

        assign sum = {1'b0, offset_q} + IW'(R);
        assign idx = (sum >= IW'(NUM_CHARS)) ? sum - IW'(NUM_CHARS) : sum;

        always_comb begin
            code = '0;
            for (int j = 0; j < NUM_CHARS; j++)
                if (idx == IW'(j)) code = char_codes[j*CHAR_W +: CHAR_W];
        end

        char_to_seg7 #(.CHAR_W(CHAR_W)) u_dec (
            .code_i (code),
            .seg_o  (seg_w[k])
        );
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            offset_q <= '0;
            presc_q  <= '0;
            step_q   <= 1'b0;
            tick_q   <= 1'b0;
            hex_q    <= '1;
        end else begin
            offset_q <= offset_d;
            presc_q  <= presc_d;
            step_q   <= step;
            tick_q   <= tick_int;
            hex_q    <= seg_w;
        end
    end

    assign hex_segs = hex_q;
    assign offset   = offset_q;
    assign tick     = tick_q;

endmodule

// File: tb/tb_scroll_word_display.sv
// Directed bench: table-driven scroll/pause/step vectors on a 4-char word plus
// hand sequences for reset, wrap/repeat on a 3-char word and blank codes.
module tb_scroll_word_display;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a, auto_a, pause_a, step_a;
    logic [7:0]  codes_a;
    logic [27:0] hex_a;
    logic [1:0]  off_a;
    logic        tick_a;
`ifdef SCROLL_DIR_EN
    logic        dir_a, dir_b;
`endif

    logic        rst_b, auto_b, pause_b, step_b;
    logic [8:0]  codes_b;
    logic [27:0] hex_b;
    logic [1:0]  off_b;
    logic        tick_b;

    scroll_word_display #(.NUM_CHARS(4), .NUM_DIGITS(4), .CHAR_W(2), .TICK_DIV(4)) dut_a (
        .CLOCK_50(clk), .reset(rst_a), .char_codes(codes_a), .auto_mode(auto_a),
        .pause(pause_a), .step(step_a),
`ifdef SCROLL_DIR_EN
        .dir(dir_a),
`endif
        .hex_segs(hex_a), .offset(off_a), .tick(tick_a));

    scroll_word_display #(.NUM_CHARS(3), .NUM_DIGITS(4), .CHAR_W(3), .TICK_DIV(1)) dut_b (
        .CLOCK_50(clk), .reset(rst_b), .char_codes(codes_b), .auto_mode(auto_b),
        .pause(pause_b), .step(step_b),
`ifdef SCROLL_DIR_EN
        .dir(dir_b),
`endif
        .hex_segs(hex_b), .offset(off_b), .tick(tick_b));

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic au, pa, st;
        int   reps;
        int   off;
        logic tk;
    } vec_t;
    vec_t tv[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [6:0] seg_of(input int c);
        case (c)
            0:       return 7'b0100001;
            1:       return 7'b0000110;
            2:       return 7'b1111001;
            3:       return 7'b1000000;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic logic [27:0] model_hex(input int off, input int nch, input int cw,
                                              input logic [31:0] codes);
        logic [27:0] r;
        r = '0;
        for (int k = 0; k < 4; k++) begin
            int idx, code;
            idx  = (off + 3 - k) % nch;
            code = int'(codes >> (idx * cw)) & ((1 << cw) - 1);
            r[k*7 +: 7] = seg_of(code);
        end
        return r;
    endfunction

    task automatic addv(input logic au, pa, st, input int reps, off, input logic tk);
        vec_t v;
        v.au = au; v.pa = pa; v.st = st; v.reps = reps; v.off = off; v.tk = tk;
        tv.push_back(v);
    endtask

    initial begin
        int prev;
        logic [31:0] cb;

        rst_a = 1'b1; auto_a = 1'b0; pause_a = 1'b0; step_a = 1'b0;
        codes_a = {2'd3, 2'd2, 2'd1, 2'd0};
        rst_b = 1'b1; auto_b = 1'b0; pause_b = 1'b0; step_b = 1'b0;
        codes_b = {3'd2, 3'd1, 3'd0};
`ifdef SCROLL_DIR_EN
        dir_a = 1'b0; dir_b = 1'b0;
`endif

        // Reset state, then the first decoded frame one cycle after release
        cyc(); cyc();
        chk("rst_hex", 32'(hex_a), 32'h0FFFFFFF);
        chk("rst_off", 32'(off_a), 32'd0);
        chk("rst_tick", 32'(tick_a), 32'd0);
        rst_a = 1'b0;
        cyc();
        chk("first_frame", 32'(hex_a), 32'({7'b0100001, 7'b0000110, 7'b1111001, 7'b1000000}));
        chk("first_off", 32'(off_a), 32'd0);

        // au pa st reps off tick
        addv(1, 0, 0, 3, 0, 0);
        addv(1, 0, 1, 1, 1, 1);   // step edge coincides with a tick: only one advance
        addv(1, 0, 0, 3, 1, 0);
        addv(1, 0, 0, 1, 2, 1);
        addv(1, 0, 0, 3, 2, 0);
        addv(1, 0, 0, 1, 3, 1);
        addv(1, 0, 0, 3, 3, 0);
        addv(1, 0, 0, 1, 0, 1);
        addv(1, 0, 0, 2, 0, 0);   // prescaler to 2
        addv(1, 1, 0, 10, 0, 0);  // paused, frozen
        addv(1, 0, 0, 1, 0, 0);
        addv(1, 0, 0, 1, 1, 1);
        addv(1, 0, 0, 2, 1, 0);   // leave auto mid-count
        addv(0, 0, 0, 1, 1, 0);
        addv(0, 0, 1, 1, 2, 0);
        addv(0, 0, 1, 4, 2, 0);   // held step: no further advance
        addv(0, 0, 0, 1, 2, 0);
        addv(0, 1, 1, 1, 2, 0);   // step while paused
        addv(0, 0, 0, 1, 2, 0);
        addv(0, 0, 1, 1, 3, 0);
        addv(0, 0, 0, 1, 3, 0);
        addv(0, 0, 1, 1, 0, 0);
        addv(0, 0, 0, 1, 0, 0);
        addv(0, 0, 1, 1, 1, 0);
        addv(0, 0, 0, 1, 1, 0);
        addv(0, 0, 1, 1, 2, 0);
        addv(0, 0, 0, 1, 2, 0);
        addv(1, 0, 0, 3, 2, 0);   // prescaler restarts from 0
        addv(1, 0, 0, 1, 3, 1);

        prev = 0;
        for (int i = 0; i < tv.size(); i++) begin
            for (int r = 0; r < tv[i].reps; r++) begin
                auto_a = tv[i].au; pause_a = tv[i].pa; step_a = tv[i].st;
                cyc();
                chk($sformatf("vec%0d_off", i), 32'(off_a), 32'(tv[i].off));
                chk($sformatf("vec%0d_tick", i), 32'(tick_a), 32'(tv[i].tk));
                chk($sformatf("vec%0d_hex", i), 32'(hex_a),
                    32'(model_hex(prev, 4, 2, 32'(codes_a))));
                prev = tv[i].off;
            end
        end

        // Reset mid-scroll overrides a step edge and auto mode
        auto_a = 1'b1; step_a = 1'b1; rst_a = 1'b1;
        cyc();
        chk("midrst_off", 32'(off_a), 32'd0);
        chk("midrst_tick", 32'(tick_a), 32'd0);
        chk("midrst_hex", 32'(hex_a), 32'h0FFFFFFF);
        rst_a = 1'b0; auto_a = 1'b0; step_a = 1'b0;
        cyc();
        chk("postrst_off", 32'(off_a), 32'd0);
        chk("postrst_hex", 32'(hex_a), 32'(model_hex(0, 4, 2, 32'(codes_a))));

`ifdef SCROLL_DIR_EN
        auto_a = 1'b1; dir_a = 1'b1;
        repeat (4) cyc();
        chk("dir_dec_wrap", 32'(off_a), 32'd3);
        repeat (3) cyc();
        dir_a = 1'b0;
        cyc();
        chk("dir_sampled", 32'(off_a), 32'd0);
        auto_a = 1'b0;
`endif

        // 3-char word, 4 digits, TICK_DIV=1: tick every cycle, wrap 2->0, HEX0 repeats
        cyc();
        chk("b_rst_hex", 32'(hex_b), 32'h0FFFFFFF);
        rst_b = 1'b0; auto_b = 1'b1;
        prev = 0;
        for (int i = 1; i <= 6; i++) begin
            cyc();
            chk($sformatf("b_off%0d", i), 32'(off_b), 32'(i % 3));
            chk($sformatf("b_tick%0d", i), 32'(tick_b), 32'd1);
            chk($sformatf("b_hex%0d", i), 32'(hex_b), 32'(model_hex(prev, 3, 3, 32'(codes_b))));
            chk($sformatf("b_rep%0d", i), 32'(hex_b[6:0]), 32'(hex_b[27:21]));
            prev = i % 3;
        end
        auto_b = 1'b0;
        codes_b = {3'd2, 3'b101, 3'd0};
        cyc();
        cb = 32'(codes_b);
        chk("b_hold_off", 32'(off_b), 32'd0);
        chk("b_blank_hex", 32'(hex_b), 32'(model_hex(0, 3, 3, cb)));
        chk("b_blank_dig", 32'(hex_b[20:14]), 32'h7F);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
